bcd_timer_ctrl: RTL and testbench

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

---
 rtl/bcd_timer_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD up/down timer with start/pause control and a
// multiplexed active-low 7-segment display driver.
module bcd_timer_ctrl #(
  parameter int SCAN_BITS = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       start_pulse,
  input  logic       dir_pulse,
  output logic [7:0] count_bcd,
  output logic       dir_up,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_sync1;
  logic r_sync2;
  logic r_hist;
  logic r_tick;
  logic w_tick;

  logic [3:0] r_ones;
  logic [3:0] r_tens;
  logic [3:0] w_ones_nxt;
  logic [3:0] w_tens_nxt;
  logic       r_dir;
  logic       w_dir_nxt;

  logic [3:0] w_step_ones;
  logic [3:0] w_step_tens;
  logic       w_at_end;
  logic       w_step_end;

  logic [SCAN_BITS-1:0] r_scan;
  logic [3:0]           w_digit;

  // Tick is registered once more so the count moves on the
  // third edge after slow_clk is first sampled high.
  assign w_tick = r_sync2 & ~r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= slow_clk;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_tick  <= w_tick;
    end
  end

  always_comb begin
    w_step_ones = r_ones;
    w_step_tens = r_tens;
    if (r_dir) begin
      if (r_ones == 4'd9) begin
        w_step_ones = 4'd0;
        w_step_tens = r_tens + 4'd1;
      end else begin
        w_step_ones = r_ones + 4'd1;
      end
    end else begin
      if (r_ones == 4'd0) begin
        w_step_ones = 4'd9;
        w_step_tens = r_tens - 4'd1;
      end else begin
        w_step_ones = r_ones - 4'd1;
      end
    end
  end

  assign w_at_end = r_dir ?
    ((r_tens == 4'd9) && (r_ones == 4'd9)) :
    ((r_tens == 4'd0) && (r_ones == 4'd0));

  assign w_step_end = r_dir ?
    ((w_step_tens == 4'd9) && (w_step_ones == 4'd9)) :
    ((w_step_tens == 4'd0) && (w_step_ones == 4'd0));

  always_comb begin
    w_state_nxt = r_state;
    w_ones_nxt  = r_ones;
    w_tens_nxt  = r_tens;
    w_dir_nxt   = r_dir;
    unique case (r_state)
      S_IDLE: begin
        if (start_pulse) begin
          w_state_nxt = S_RUN;
        end else if (dir_pulse) begin
          w_dir_nxt  = ~r_dir;
          w_ones_nxt = r_dir ? 4'd9 : 4'd0;
          w_tens_nxt = r_dir ? 4'd9 : 4'd0;
        end
      end
      S_RUN: begin
        if (start_pulse) begin
          w_state_nxt = S_PAUSE;
        end else if (r_tick) begin
          if (w_at_end) begin
            w_state_nxt = S_DONE;
          end else begin
            w_ones_nxt = w_step_ones;
            w_tens_nxt = w_step_tens;
            if (w_step_end) begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_PAUSE: begin
        if (start_pulse) begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (start_pulse) begin
          w_state_nxt = S_IDLE;
          w_ones_nxt  = r_dir ? 4'd0 : 4'd9;
          w_tens_nxt  = r_dir ? 4'd0 : 4'd9;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ones  <= 4'd0;
      r_tens  <= 4'd0;
      r_dir   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ones  <= w_ones_nxt;
      r_tens  <= w_tens_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
    end else begin
      r_scan <= r_scan + SCAN_BITS'(1);
    end
  end

  assign count_bcd = {r_tens, r_ones};
  assign dir_up    = r_dir;
  assign done      = (r_state == S_DONE);

  assign an      = r_scan[SCAN_BITS-1] ? 4'b1101 : 4'b1110;
  assign w_digit = r_scan[SCAN_BITS-1] ? r_tens : r_ones;

  always_comb begin
    seg = 7'b1111111;
    unique case (w_digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl: directed steps plus a
// random phase, all compared against an arithmetic reference model.
module tb_bcd_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slow_clk = 1'b0;
  logic       start_pulse = 1'b0;
  logic       dir_pulse = 1'b0;
  logic [7:0] count_bcd;
  logic       dir_up;
  logic       done;
  logic [3:0] an;
  logic [6:0] seg;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_timer_ctrl #(.SCAN_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .slow_clk(slow_clk),
    .start_pulse(start_pulse),
    .dir_pulse(dir_pulse),
    .count_bcd(count_bcd),
    .dir_up(dir_up),
    .done(done),
    .an(an),
    .seg(seg)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t      m_mode;
  int         m_cnt;
  bit         m_up;
  logic [3:0] m_hist;
  int         m_scan;
  logic [6:0] seg_tab [0:9];
  logic       m_tk;
  int         m_nc;

  // m_hist[k] holds slow_clk as sampled k+1 edges ago; a rising
  // edge sampled 3 edges back is the one consumed now.
  assign m_tk = m_hist[2] & ~m_hist[3];
  assign m_nc = m_cnt + (m_up ? 1 : -1);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_IDLE;
      m_cnt  <= 0;
      m_up   <= 1'b1;
      m_hist <= 4'b0;
      m_scan <= 0;
    end else begin
      m_hist <= {m_hist[2:0], slow_clk};
      m_scan <= (m_scan + 1) % 16;
      case (m_mode)
        M_IDLE:
          if (start_pulse) m_mode <= M_RUN;
          else if (dir_pulse) begin
            m_up  <= !m_up;
            m_cnt <= m_up ? 99 : 0;
          end
        M_RUN:
          if (start_pulse) m_mode <= M_PAUSE;
          else if (m_tk) begin
            m_cnt <= m_nc;
            if ((m_up && m_nc == 99) || (!m_up && m_nc == 0))
              m_mode <= M_DONE;
          end
        M_PAUSE:
          if (start_pulse) m_mode <= M_RUN;
        M_DONE:
          if (start_pulse) begin
            m_mode <= M_IDLE;
            m_cnt  <= m_up ? 0 : 99;
          end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e_cnt;
    logic [3:0] e_an;
    int d;
    e_cnt = {4'(m_cnt / 10), 4'(m_cnt % 10)};
    e_an  = (m_scan >= 8) ? 4'b1101 : 4'b1110;
    d     = (m_scan >= 8) ? m_cnt / 10 : m_cnt % 10;
    chk({tag, ".count"}, count_bcd, e_cnt);
    chk({tag, ".dir"}, {7'b0, dir_up}, {7'b0, m_up});
    chk({tag, ".done"}, {7'b0, done}, {7'b0, m_mode == M_DONE});
    chk({tag, ".an"}, {4'b0, an}, {4'b0, e_an});
    chk({tag, ".seg"}, {1'b0, seg}, {1'b0, seg_tab[d]});
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all("model");
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1;
    cyc();
    start_pulse = 1'b0;
  endtask

  task automatic pulse_dir();
    dir_pulse = 1'b1;
    cyc();
    dir_pulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      slow_clk = 1'b1;
      repeat ($urandom_range(1, 3)) cyc();
      slow_clk = 1'b0;
      repeat ($urandom_range(1, 3)) cyc();
    end
    repeat (4) cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".count"}, count_bcd, 8'h00);
    chk({tag, ".dir"}, {7'b0, dir_up}, 8'h01);
    chk({tag, ".done"}, {7'b0, done}, 8'h00);
    chk({tag, ".an"}, {4'b0, an}, 8'h0E);
    chk({tag, ".seg"}, {1'b0, seg}, 8'h40);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    cyc();

    // count up with exact latency on the first step
    pulse_start();
    slow_clk = 1'b1;
    cyc(); chk("lat.e0", count_bcd, 8'h00);
    cyc(); chk("lat.e1", count_bcd, 8'h00);
    cyc(); chk("lat.e2", count_bcd, 8'h00);
    slow_clk = 1'b0;
    cyc(); chk("lat.e3", count_bcd, 8'h01);
    repeat (2) cyc();
    ticks(9);
    chk("up.10", count_bcd, 8'h10);
    ticks(2);
    chk("up.12", count_bcd, 8'h12);

    ticks(87);
    chk("up.99", count_bcd, 8'h99);
    chk("up.done", {7'b0, done}, 8'h01);
    ticks(3);
    chk("up.hold", count_bcd, 8'h99);
    pulse_start();
    chk("up.reload", count_bcd, 8'h00);
    chk("up.idle", {7'b0, done}, 8'h00);

    // count down
    pulse_dir();
    chk("dn.dir", {7'b0, dir_up}, 8'h00);
    chk("dn.99", count_bcd, 8'h99);
    pulse_start();
    ticks(100);
    chk("dn.00", count_bcd, 8'h00);
    chk("dn.done", {7'b0, done}, 8'h01);
    ticks(3);
    chk("dn.hold", count_bcd, 8'h00);
    pulse_start();
    chk("dn.reload", count_bcd, 8'h99);
    pulse_dir();
    chk("dn.back", count_bcd, 8'h00);

    // start coinciding with a tick in RUN and in PAUSE
    pulse_start();
    ticks(5);
    chk("co.05", count_bcd, 8'h05);
    slow_clk = 1'b1;
    repeat (3) cyc();
    slow_clk = 1'b0;
    start_pulse = 1'b1;
    cyc();
    start_pulse = 1'b0;
    repeat (3) cyc();
    chk("co.pause", count_bcd, 8'h05);
    pulse_dir();
    chk("co.dirign", {7'b0, dir_up}, 8'h01);
    ticks(2);
    chk("co.held", count_bcd, 8'h05);
    pulse_start();
    ticks(1);
    chk("co.06", count_bcd, 8'h06);
    pulse_start();
    slow_clk = 1'b1;
    repeat (3) cyc();
    slow_clk = 1'b0;
    start_pulse = 1'b1;
    cyc();
    start_pulse = 1'b0;
    repeat (3) cyc();
    chk("co.resume", count_bcd, 8'h06);
    ticks(1);
    chk("co.07", count_bcd, 8'h07);

    // async reset mid-run
    ticks(30);
    chk("rs.37", count_bcd, 8'h37);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rs.async");
    repeat (2) cyc();
    rst = 1'b0;
    ticks(3);
    chk("rs.ignore", count_bcd, 8'h00);

    // display scan at 42
    pulse_start();
    ticks(42);
    pulse_start();
    chk("dsp.42", count_bcd, 8'h42);
    for (int i = 0; i < 32; i++) begin
      cyc();
      if (an == 4'b1110)
        chk("dsp.ones", {1'b0, seg}, 8'h24);
      else
        chk("dsp.tens", {1'b0, seg}, 8'h19);
    end

    // random phase
    pulse_start();
    for (int i = 0; i < 800; i++) begin
      slow_clk    = 1'($urandom_range(0, 1));
      start_pulse = ($urandom_range(0, 39) == 0);
      dir_pulse   = ($urandom_range(0, 11) == 0);
      cyc();
    end
    start_pulse = 1'b0;
    dir_pulse   = 1'b0;
    slow_clk    = 1'b0;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
